life_support_sequencer: RTL and testbench
=========================================

Name: life_support_sequencer

Overview:
- Mode and supply controller for the LifeSupport datapath.
- Arbitrates crew requests (defense, stealth) against ship-health conditions (oxygen, power, temperature, fatal).
- Drives the LifeSupport control inputs `mode`, `chrg` and `o2sup` from a registered priority FSM, with dwell and cooldown timers.
- Sits between the command console and LifeSupport; reads back LifeSupport's `outpower`, `outo2`, `outtemp` and `fatal`.

Parameters:
- N, 32: width of the power, O2 and temperature buses.
- PWR_LOW, 20: outpower below this forces CHARGE.
- PWR_TGT, 200: CHARGE exits at outpower >= this.
- O2_LOW, 50: outo2 below this forces REFILL.
- O2_TGT, 150: REFILL exits at outo2 >= this.
- TEMP_MAX, 90: outtemp >= this aborts STEALTH.
- DWELL, 8: minimum cycles in DEFENSE/STEALTH; also the fatal-clear qualification time in SAFE.
- COOL, 16: cycles after STEALTH exit during which STEALTH is not granted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rise).
- req_def  in  1  crew defense request (level).
- req_sth  in  1  crew stealth request (level).
- atk  in  1  attack indication (level); treated as an implicit defense request.
- outpower  in  N  LifeSupport power readback.
- outo2  in  N  LifeSupport O2 readback.
- outtemp  in  N  LifeSupport temperature readback.
- fatal  in  1  LifeSupport fatal flag.
- mode  out  4  to LifeSupport: 4'b0000 idle, 4'b0100 defense, 4'b1000 stealth.
- chrg  out  1  to LifeSupport charge select.
- o2sup  out  1  to LifeSupport O2 supply select.
- state  out  3  current FSM state (debug/telemetry).
- sth_blocked  out  1  stealth cooldown active.
- alarm  out  1  high in SAFE.

Behaviour:
- State encoding: IDLE=0, DEFENSE=1, STEALTH=2, CHARGE=3, REFILL=4, SAFE=5. Codes 6 and 7 go to IDLE on the next clock.
- Reset (rst==0 at clk rise) forces: state=IDLE, mode=0, chrg=0, o2sup=0, alarm=0, dwell_cnt=0, cool_cnt=0, sth_blocked=0, safe_cnt=0. Reset overrides all other events, including mid-dwell and mid-charge.
- Outputs are registered and decoded from the state register (Moore):
  - IDLE: mode=0, chrg=0, o2sup=0.
  - DEFENSE: mode=4'b0100.
  - STEALTH: mode=4'b1000.
  - CHARGE: chrg=1, mode=0.
  - REFILL: o2sup=1, mode=0.
  - SAFE: mode=0, chrg=1, o2sup=1, alarm=1.
  - Latency: an input change sampled at edge k is reflected on the outputs after edge k.
- Comparisons are unsigned N-bit; no arithmetic on the readbacks.
- Global priority, evaluated every cycle from any state (highest first):
  1. fatal: go to SAFE.
  2. outo2 < O2_LOW: go to REFILL, unless already in SAFE.
  3. Remaining rules are state-specific, below.
- IDLE:
  - outpower < PWR_LOW: go to CHARGE.
  - else (req_def | atk): go to DEFENSE.
  - else req_sth & !sth_blocked: go to STEALTH.
  - otherwise stay.
- DEFENSE:
  - On entry, dwell_cnt loads DWELL-1; it decrements to 0 and saturates there.
  - outpower==0: go to CHARGE immediately, ignoring dwell.
  - dwell_cnt==0 & !(req_def|atk): go to IDLE.
- STEALTH:
  - On entry, dwell_cnt loads DWELL-1.
  - (req_def|atk): go to DEFENSE immediately; defense preempts stealth.
  - outtemp >= TEMP_MAX or outpower==0: go to IDLE (power==0 goes to CHARGE instead).
  - dwell_cnt==0 & !req_sth: go to IDLE.
  - On any exit from STEALTH, cool_cnt loads COOL; it decrements each cycle to 0. sth_blocked = (cool_cnt != 0).
- CHARGE:
  - outpower >= PWR_TGT: go to IDLE.
  - Requests are ignored except via global priority.
- REFILL:
  - outo2 >= O2_TGT: go to IDLE.
  - If outpower < PWR_LOW at exit, go to CHARGE instead.
- SAFE:
  - safe_cnt increments while fatal==0 and clears to 0 when fatal==1.
  - When safe_cnt reaches DWELL, go to IDLE and clear safe_cnt.
- Simultaneous events resolve strictly by the priority order above.
- A request arriving while its state is already active only holds the state; it does not restart dwell.

Test Plan:
- Reset: rst=0 for 2 cycles with all requests high → mode=0, chrg=0, o2sup=0, state=0. Release with outpower=100, outo2=100, req_def=1 → state=1, mode=4'b0100 one cycle later.
- Dwell: req_def pulse of 1 cycle with outpower=100 → DEFENSE held for exactly 8 cycles, then IDLE.
- Stealth cooldown: req_sth=1 for 10 cycles with outtemp=50, then drop → IDLE, sth_blocked=1. Re-assert req_sth during the next 16 cycles → stays IDLE; on cycle 17 → STEALTH.
- Stealth preempt: in STEALTH, assert atk → DEFENSE the next cycle. Separately, in STEALTH with outtemp=90 → IDLE and cooldown starts.
- Resource priority: in DEFENSE with outpower=100, set outo2=40 → REFILL with o2sup=1. Raise outo2 to 150 with outpower=10 → CHARGE. Raise outpower to 200 → IDLE.
- Fatal: fatal=1 in any state → SAFE with alarm=1, chrg=1, o2sup=1. Drop fatal for 5 cycles, pulse it, then drop for 8 cycles → IDLE only after the full 8 clean cycles.

Source files
------------

// File: rtl/life_support_sequencer.sv
// life_support_sequencer
// Priority mode/supply controller for the LifeSupport datapath. Crew requests
// (defense, stealth, attack) are arbitrated against ship health (fatal, O2,
// power, temperature) by a registered Moore FSM with dwell and cooldown timers.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   req_def      crew defense request (level)
//   req_sth      crew stealth request (level)
//   atk          attack indication, acts as an implicit defense request
//   outpower     LifeSupport power readback (N bits, unsigned)
//   outo2        LifeSupport O2 readback (N bits, unsigned)
//   outtemp      LifeSupport temperature readback (N bits, unsigned)
//   fatal        LifeSupport fatal flag
//   mode         LifeSupport mode: 0000 idle, 0100 defense, 1000 stealth
//   chrg         LifeSupport charge select
//   o2sup        LifeSupport O2 supply select
//   state        current FSM state code (telemetry)
//   sth_blocked  stealth cooldown active
//   alarm        high while in SAFE
module life_support_sequencer #(
  parameter int unsigned N        = 32,
  parameter int unsigned PWR_LOW  = 20,
  parameter int unsigned PWR_TGT  = 200,
  parameter int unsigned O2_LOW   = 50,
  parameter int unsigned O2_TGT   = 150,
  parameter int unsigned TEMP_MAX = 90,
  parameter int unsigned DWELL    = 8,
  parameter int unsigned COOL     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_def,
  input  logic         req_sth,
  input  logic         atk,
  input  logic [N-1:0] outpower,
  input  logic [N-1:0] outo2,
  input  logic [N-1:0] outtemp,
  input  logic         fatal,
  output logic [3:0]   mode,
  output logic         chrg,
  output logic         o2sup,
  output logic [2:0]   state,
  output logic         sth_blocked,
  output logic         alarm
);

  localparam int unsigned DW = $clog2(DWELL + 1);
  localparam int unsigned CW = $clog2(COOL + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEFENSE = 3'd1,
    S_STEALTH = 3'd2,
    S_CHARGE  = 3'd3,
    S_REFILL  = 3'd4,
    S_SAFE    = 3'd5
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] dwell_d;
  logic [CW-1:0] cool_cnt;
  logic [CW-1:0] cool_d;
  logic [DW-1:0] safe_cnt;
  logic [DW-1:0] safe_d;

  logic [3:0]    mode_d;
  logic          chrg_d;
  logic          o2sup_d;
  logic          alarm_d;

  // Readback qualifiers, all unsigned N-bit compares
  logic def_want_c;
  logic pwr_low_c;
  logic pwr_zero_c;
  logic pwr_full_c;
  logic o2_low_c;
  logic o2_full_c;
  logic temp_hot_c;
  logic blocked_c;
  logic dwell_done_c;
  logic safe_done_c;

  assign def_want_c   = req_def | atk;
  assign pwr_low_c    = outpower <  N'(PWR_LOW);
  assign pwr_zero_c   = outpower == '0;
  assign pwr_full_c   = outpower >= N'(PWR_TGT);
  assign o2_low_c     = outo2    <  N'(O2_LOW);
  assign o2_full_c    = outo2    >= N'(O2_TGT);
  assign temp_hot_c   = outtemp  >= N'(TEMP_MAX);
  assign blocked_c    = cool_cnt != '0;
  assign dwell_done_c = dwell_cnt == '0;
  // The DWELL-th consecutive clean sample releases SAFE on that same edge
  assign safe_done_c  = !fatal && (safe_cnt == DW'(DWELL - 1));

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dwell_cnt   <= '0;
      cool_cnt    <= '0;
      safe_cnt    <= '0;
      mode        <= 4'b0000;
      chrg        <= 1'b0;
      o2sup       <= 1'b0;
      alarm       <= 1'b0;
      sth_blocked <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt   <= dwell_d;
      cool_cnt    <= cool_d;
      safe_cnt    <= safe_d;
      mode        <= mode_d;
      chrg        <= chrg_d;
      o2sup       <= o2sup_d;
      alarm       <= alarm_d;
      sth_blocked <= cool_d != '0;
    end
  end

  assign state = state_q;

  // Next-state and timer update
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_cnt;
    cool_d  = cool_cnt;
    safe_d  = '0;

    if (fatal) begin
      state_d = S_SAFE;
    end else if (o2_low_c && (state_q != S_SAFE)) begin
      state_d = S_REFILL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pwr_low_c)                   state_d = S_CHARGE;
          else if (def_want_c)             state_d = S_DEFENSE;
          else if (req_sth && !blocked_c)  state_d = S_STEALTH;
        end
        S_DEFENSE: begin
          if (pwr_zero_c)                        state_d = S_CHARGE;
          else if (dwell_done_c && !def_want_c)  state_d = S_IDLE;
        end
        S_STEALTH: begin
          if (def_want_c)                     state_d = S_DEFENSE;
          else if (pwr_zero_c)                state_d = S_CHARGE;
          else if (temp_hot_c)                state_d = S_IDLE;
          else if (dwell_done_c && !req_sth)  state_d = S_IDLE;
        end
        S_CHARGE: begin
          if (pwr_full_c) state_d = S_IDLE;
        end
        S_REFILL: begin
          if (o2_full_c) state_d = pwr_low_c ? S_CHARGE : S_IDLE;
        end
        S_SAFE: begin
          if (safe_done_c) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Dwell loads only on a real entry; a held request never restarts it
    if (((state_d == S_DEFENSE) || (state_d == S_STEALTH)) && (state_d != state_q)) begin
      dwell_d = DW'(DWELL - 1);
    end else if (!dwell_done_c) begin
      dwell_d = dwell_cnt - DW'(1);
    end

    // Cooldown arms on any departure from STEALTH
    if ((state_q == S_STEALTH) && (state_d != S_STEALTH)) begin
      cool_d = CW'(COOL);
    end else if (blocked_c) begin
      cool_d = cool_cnt - CW'(1);
    end

    // Clean-cycle count in SAFE; any fatal sample restarts qualification
    if ((state_q == S_SAFE) && !fatal && !safe_done_c) begin
      safe_d = safe_cnt + DW'(1);
    end
  end

  // Moore decode of the upcoming state, registered alongside it
  always_comb begin
    mode_d  = 4'b0000;
    chrg_d  = 1'b0;
    o2sup_d = 1'b0;
    alarm_d = 1'b0;
    case (state_d)
      S_DEFENSE: mode_d = 4'b0100;
      S_STEALTH: mode_d = 4'b1000;
      S_CHARGE:  chrg_d = 1'b1;
      S_REFILL:  o2sup_d = 1'b1;
      S_SAFE: begin
        chrg_d  = 1'b1;
        o2sup_d = 1'b1;
        alarm_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_life_support_sequencer.sv
// Directed-vector bench for life_support_sequencer. Each stimulus cycle pushes
// the hand-derived post-edge outputs into a queue; a negedge monitor pops and
// compares them against the DUT.
module tb_life_support_sequencer;

  localparam int unsigned N = 32;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] mode;
    logic       chrg;
    logic       o2sup;
    logic       alarm;
    logic       blk;
  } obs_t;

  logic         clk;
  logic         rst;
  logic         req_def;
  logic         req_sth;
  logic         atk;
  logic [N-1:0] outpower;
  logic [N-1:0] outo2;
  logic [N-1:0] outtemp;
  logic         fatal;
  logic [3:0]   mode;
  logic         chrg;
  logic         o2sup;
  logic [2:0]   state;
  logic         sth_blocked;
  logic         alarm;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_mis = 0;

  localparam logic [2:0] IDLE = 3'd0, DEF = 3'd1, STH = 3'd2,
                         CHG = 3'd3, REF = 3'd4, SAFE = 3'd5;

  life_support_sequencer dut (
    .clk(clk), .rst(rst), .req_def(req_def), .req_sth(req_sth), .atk(atk),
    .outpower(outpower), .outo2(outo2), .outtemp(outtemp), .fatal(fatal),
    .mode(mode), .chrg(chrg), .o2sup(o2sup), .state(state),
    .sth_blocked(sth_blocked), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output table for each state code
  function automatic obs_t expect_of(input logic [2:0] st, input logic blk);
    obs_t o;
    o = '0;
    o.st  = st;
    o.blk = blk;
    case (st)
      DEF:  o.mode = 4'b0100;
      STH:  o.mode = 4'b1000;
      CHG:  o.chrg = 1'b1;
      REF:  o.o2sup = 1'b1;
      SAFE: begin o.chrg = 1'b1; o.o2sup = 1'b1; o.alarm = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // One clock: inputs already driven; expectation queued for the outputs after this edge
  task automatic step(input logic [2:0] st, input logic blk, input string tag);
    @(posedge clk);
    exp_q.push_back(expect_of(st, blk));
    tag_q.push_back(tag);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e;
      obs_t  g;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = '{st: state, mode: mode, chrg: chrg, o2sup: o2sup, alarm: alarm, blk: sth_blocked};
      n_vec++;
      if (g !== e) begin
        n_mis++;
        $display("FAIL %s @%0t: got st=%0d mode=%b chrg=%b o2sup=%b alarm=%b blk=%b, want st=%0d mode=%b chrg=%b o2sup=%b alarm=%b blk=%b",
                 t, $time, g.st, g.mode, g.chrg, g.o2sup, g.alarm, g.blk,
                 e.st, e.mode, e.chrg, e.o2sup, e.alarm, e.blk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_def = 1'b1; req_sth = 1'b1; atk = 1'b1; fatal = 1'b0;
    outpower = 32'd100; outo2 = 32'd100; outtemp = 32'd50;

    // Reset with every request high
    step(IDLE, 1'b0, "reset0");
    step(IDLE, 1'b0, "reset1");

    // Release with req_def: defense one cycle later, then an 8-cycle dwell
    rst = 1'b1; req_sth = 1'b0; atk = 1'b0;
    step(DEF, 1'b0, "release_def");
    req_def = 1'b0;
    for (int i = 0; i < 7; i++) step(DEF, 1'b0, "dwell_a");
    step(IDLE, 1'b0, "dwell_a_exit");

    // One-cycle defense pulse
    req_def = 1'b1;
    step(DEF, 1'b0, "pulse_enter");
    req_def = 1'b0;
    for (int i = 0; i < 7; i++) step(DEF, 1'b0, "pulse_dwell");
    step(IDLE, 1'b0, "pulse_exit");

    // Stealth for 10 cycles, drop, then cooldown
    req_sth = 1'b1;
    for (int i = 0; i < 10; i++) step(STH, 1'b0, "sth_hold");
    req_sth = 1'b0;
    step(IDLE, 1'b1, "sth_exit");
    req_sth = 1'b1;
    for (int i = 0; i < 15; i++) step(IDLE, 1'b1, "cool_block");
    step(IDLE, 1'b0, "cool_last");
    step(STH, 1'b0, "cool_grant");

    // Attack preempts stealth; cooldown arms on that exit
    atk = 1'b1; req_sth = 1'b0;
    step(DEF, 1'b1, "atk_preempt");
    atk = 1'b0;
    for (int i = 0; i < 7; i++) step(DEF, 1'b1, "preempt_dwell");
    step(IDLE, 1'b1, "preempt_exit");
    for (int i = 0; i < 7; i++) step(IDLE, 1'b1, "cool_drain");
    step(IDLE, 1'b0, "cool_clear");

    // Over-temperature aborts stealth
    req_sth = 1'b1;
    step(STH, 1'b0, "sth_reenter");
    outtemp = 32'd90;
    step(IDLE, 1'b1, "temp_abort");
    outtemp = 32'd50; req_sth = 1'b0;

    // Resource priority: O2 over defense, refill to charge, charge to idle
    req_def = 1'b1;
    step(DEF, 1'b1, "res_def");
    outo2 = 32'd40;
    step(REF, 1'b1, "o2_low");
    req_def = 1'b0; outo2 = 32'd100;
    step(REF, 1'b1, "refill_hold");
    outo2 = 32'd150; outpower = 32'd10;
    step(CHG, 1'b1, "refill_to_chg");
    outpower = 32'd100; req_def = 1'b1;
    step(CHG, 1'b1, "chg_ignores_req");
    req_def = 1'b0; outpower = 32'd200;
    step(IDLE, 1'b1, "chg_full");
    outpower = 32'd100;

    // Fatal: clean-cycle qualification restarts on any fatal sample
    fatal = 1'b1;
    step(SAFE, 1'b1, "fatal_enter");
    fatal = 1'b0;
    step(SAFE, 1'b1, "safe_clean1");
    step(SAFE, 1'b1, "safe_clean2");
    step(SAFE, 1'b1, "safe_clean3");
    step(SAFE, 1'b1, "safe_clean4");
    step(SAFE, 1'b1, "safe_clean5");
    fatal = 1'b1;
    step(SAFE, 1'b1, "fatal_pulse");
    fatal = 1'b0;
    step(SAFE, 1'b1, "requal1");
    step(SAFE, 1'b1, "requal2");
    for (int i = 0; i < 5; i++) step(SAFE, 1'b0, "requal3_7");
    step(IDLE, 1'b0, "safe_release");

    // Fatal beats low O2; low O2 does not pull out of SAFE
    req_def = 1'b1;
    step(DEF, 1'b0, "pre_fatal_def");
    fatal = 1'b1; outo2 = 32'd40;
    step(SAFE, 1'b0, "fatal_over_o2");
    fatal = 1'b0; req_def = 1'b0;
    for (int i = 0; i < 7; i++) step(SAFE, 1'b0, "safe_o2low");
    step(IDLE, 1'b0, "safe_release_o2");
    step(REF, 1'b0, "idle_to_refill");
    outo2 = 32'd150;
    step(IDLE, 1'b0, "refill_to_idle");
    outo2 = 32'd100;

    // Power thresholds
    outpower = 32'd20;
    step(IDLE, 1'b0, "pwr_at_low");
    outpower = 32'd19;
    step(CHG, 1'b0, "pwr_below_low");
    outpower = 32'd199;
    step(CHG, 1'b0, "pwr_below_tgt");
    outpower = 32'd200;
    step(IDLE, 1'b0, "pwr_at_tgt");
    outpower = 32'd100; req_def = 1'b1;
    step(DEF, 1'b0, "def_pwr");
    outpower = 32'd0;
    step(CHG, 1'b0, "def_pwr_zero");
    outpower = 32'd200; req_def = 1'b0;
    step(IDLE, 1'b0, "chg_exit");
    outpower = 32'd100;

    // Reset mid-dwell
    req_def = 1'b1;
    step(DEF, 1'b0, "mid_dwell");
    rst = 1'b0;
    step(IDLE, 1'b0, "reset_mid_dwell");
    rst = 1'b1; req_def = 1'b0;
    step(IDLE, 1'b0, "post_reset");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
